// File: rtl/axi_id_alloc_ctrl.sv
// Slot allocator for an AXI ID remapper: maps wide master IDs onto TableSize narrow IDs with per-slot txn counters.
// Optional statistics (peak slot usage, stall cycles) are built when AXI_ID_ALLOC_STATS_EN is defined.
module axi_id_alloc_ctrl #(
  parameter int InIdWidth    = 8,
  parameter int OutIdWidth   = 4,
  parameter int TableSize    = 4,
  parameter int MaxTxnsPerId = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_valid_i,
  input  logic [InIdWidth-1:0]  alloc_id_i,
  output logic                  alloc_ready_o,
  output logic [OutIdWidth-1:0] alloc_oup_id_o,
  input  logic                  free_valid_i,
  input  logic [OutIdWidth-1:0] free_oup_id_i,
  output logic [InIdWidth-1:0]  free_inp_id_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  err_o
`ifdef AXI_ID_ALLOC_STATS_EN
  ,
  output logic [$clog2(TableSize+1)-1:0] peak_used_o,
  output logic [15:0]                    stall_cnt_o
`endif
);

  localparam int CntW  = $clog2(MaxTxnsPerId + 1);
  localparam int UsedW = $clog2(TableSize + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxnsPerId);

  logic [CntW-1:0]      cnt_reg    [TableSize];
  logic [InIdWidth-1:0] inp_id_reg [TableSize];
  logic                 err_reg;

  logic [TableSize-1:0]  slot_valid, id_match, free_sel, alloc_sel;
  logic                  hit, hit_room, fire, free_ok;
  logic [OutIdWidth-1:0] hit_idx, miss_idx;

  for (genvar gi = 0; gi < TableSize; gi++) begin : g_slot
    assign slot_valid[gi] = (cnt_reg[gi] != '0);
    assign id_match[gi]   = slot_valid[gi] && (inp_id_reg[gi] == alloc_id_i);
    assign free_sel[gi]   = free_valid_i && (free_oup_id_i == OutIdWidth'(gi));
    assign alloc_sel[gi]  = fire && (alloc_oup_id_o == OutIdWidth'(gi));
  end

  assign full_o  = &slot_valid;
  assign empty_o = ~|slot_valid;
  assign err_o   = err_reg;
  assign hit     = |id_match;
  assign free_ok = |(free_sel & slot_valid);

  // Descending scans leave the lowest matching index; a full table falls back to slot 0.
  always_comb begin
    hit_idx       = '0;
    hit_room      = 1'b0;
    miss_idx      = '0;
    free_inp_id_o = '0;
    for (int i = TableSize - 1; i >= 0; i--) begin
      if (id_match[i]) begin
        hit_idx  = OutIdWidth'(i);
        hit_room = (cnt_reg[i] < MaxCnt);
      end
      if (!slot_valid[i]) miss_idx = OutIdWidth'(i);
    end
    for (int i = 0; i < TableSize; i++) begin
      if (free_oup_id_i == OutIdWidth'(i)) free_inp_id_o = inp_id_reg[i];
    end
  end

  // Grant uses registered state only, so a same-cycle free never unblocks the request early.
  assign alloc_oup_id_o = hit ? hit_idx : miss_idx;
  assign alloc_ready_o  = hit ? hit_room : !full_o;
  assign fire           = alloc_valid_i && alloc_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < TableSize; i++) begin
        cnt_reg[i]    <= '0;
        inp_id_reg[i] <= '0;
      end
      err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < TableSize; i++) begin
        if (alloc_sel[i] && !(free_sel[i] && slot_valid[i])) begin
          cnt_reg[i] <= cnt_reg[i] + CntW'(1);
        end else if (!alloc_sel[i] && free_sel[i] && slot_valid[i]) begin
          cnt_reg[i] <= cnt_reg[i] - CntW'(1);
        end
        if (alloc_sel[i] && !hit) inp_id_reg[i] <= alloc_id_i;
      end
      err_reg <= free_valid_i && !free_ok;
    end
  end

`ifdef AXI_ID_ALLOC_STATS_EN
  logic [UsedW-1:0] used_cnt;
  logic [UsedW-1:0] peak_used_reg;
  logic [15:0]      stall_cnt_reg;

  always_comb begin
    used_cnt = '0;
    for (int i = 0; i < TableSize; i++) used_cnt = used_cnt + UsedW'(slot_valid[i]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      peak_used_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (used_cnt > peak_used_reg) peak_used_reg <= used_cnt;
      if (alloc_valid_i && !alloc_ready_o && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign peak_used_o = peak_used_reg;
  assign stall_cnt_o = stall_cnt_reg;
`endif

  for (genvar gi = 0; gi < TableSize; gi++) begin : g_cnt_chk
    a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i) cnt_reg[gi] <= MaxCnt);
  end

  a_id_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (alloc_valid_i && !alloc_ready_o) |=> $stable(alloc_id_i));

endmodule

// File: tb/tb_axi_id_alloc_ctrl.sv
// Directed, table-driven bench for axi_id_alloc_ctrl (TableSize=4, MaxTxnsPerId=4), plus a reset sequence.
module tb_axi_id_alloc_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       alloc_valid_i = 1'b0;
  logic [7:0] alloc_id_i = 8'h00;
  logic       alloc_ready_o;
  logic [3:0] alloc_oup_id_o;
  logic       free_valid_i = 1'b0;
  logic [3:0] free_oup_id_i = 4'h0;
  logic [7:0] free_inp_id_o;
  logic       full_o, empty_o, err_o;
`ifdef AXI_ID_ALLOC_STATS_EN
  logic [2:0]  peak_used_o;
  logic [15:0] stall_cnt_o;
`endif

  int checks = 0;
  int failures = 0;
  int stall_exp = 0;

  always #5 clk_i = ~clk_i;

  axi_id_alloc_ctrl #(
    .InIdWidth(8), .OutIdWidth(4), .TableSize(4), .MaxTxnsPerId(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_id_i(alloc_id_i),
    .alloc_ready_o(alloc_ready_o), .alloc_oup_id_o(alloc_oup_id_o),
    .free_valid_i(free_valid_i), .free_oup_id_i(free_oup_id_i),
    .free_inp_id_o(free_inp_id_o),
    .full_o(full_o), .empty_o(empty_o), .err_o(err_o)
`ifdef AXI_ID_ALLOC_STATS_EN
    , .peak_used_o(peak_used_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  typedef struct {
    logic       av;
    logic [7:0] aid;
    logic       fv;
    logic [3:0] fid;
    logic       chk_inp;
    logic [7:0] e_inp;
    logic       e_rdy;
    logic [3:0] e_oup;
    logic       e_full;
    logic       e_empty;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [7:0] aid, logic fv, logic [3:0] fid,
                              logic chk_inp, logic [7:0] e_inp, logic e_rdy, logic [3:0] e_oup,
                              logic e_full, logic e_empty, logic e_err);
    vec_t v;
    v.av = av; v.aid = aid; v.fv = fv; v.fid = fid; v.chk_inp = chk_inp; v.e_inp = e_inp;
    v.e_rdy = e_rdy; v.e_oup = e_oup; v.e_full = e_full; v.e_empty = e_empty; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    // av aid  fv fid chk inp   rdy oup full empty err
    // scenario 1: fill, stall on full, free slot 1, grant next cycle
    vecs.push_back(mk(0, 8'h00, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 1, 0)); // 0
    vecs.push_back(mk(1, 8'h12, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 1, 0)); // 1
    vecs.push_back(mk(1, 8'h34, 0, 4'd0, 0, 8'h00, 1, 4'd1, 0, 0, 0)); // 2
    vecs.push_back(mk(1, 8'h56, 0, 4'd0, 0, 8'h00, 1, 4'd2, 0, 0, 0)); // 3
    vecs.push_back(mk(1, 8'h78, 0, 4'd0, 0, 8'h00, 1, 4'd3, 0, 0, 0)); // 4
    vecs.push_back(mk(1, 8'h9A, 0, 4'd0, 0, 8'h00, 0, 4'd0, 1, 0, 0)); // 5
    vecs.push_back(mk(1, 8'h9A, 1, 4'd1, 1, 8'h34, 0, 4'd0, 1, 0, 0)); // 6
    vecs.push_back(mk(1, 8'h9A, 0, 4'd0, 0, 8'h00, 1, 4'd1, 0, 0, 0)); // 7
    vecs.push_back(mk(0, 8'h00, 0, 4'd0, 0, 8'h00, 0, 4'd0, 1, 0, 0)); // 8
    vecs.push_back(mk(0, 8'h00, 1, 4'd0, 1, 8'h12, 0, 4'd0, 1, 0, 0)); // 9
    vecs.push_back(mk(0, 8'h00, 1, 4'd1, 1, 8'h9A, 1, 4'd0, 0, 0, 0)); // 10
    vecs.push_back(mk(0, 8'h00, 1, 4'd2, 1, 8'h56, 1, 4'd0, 0, 0, 0)); // 11
    vecs.push_back(mk(0, 8'h00, 1, 4'd3, 1, 8'h78, 1, 4'd0, 0, 0, 0)); // 12
    vecs.push_back(mk(0, 8'h00, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 1, 0)); // 13
    // scenario 2: per-slot limit, hit never spills
    vecs.push_back(mk(1, 8'h12, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 1, 0)); // 14
    vecs.push_back(mk(1, 8'h12, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 0, 0)); // 15
    vecs.push_back(mk(1, 8'h12, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 0, 0)); // 16
    vecs.push_back(mk(1, 8'h12, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 0, 0)); // 17
    vecs.push_back(mk(1, 8'h12, 0, 4'd0, 0, 8'h00, 0, 4'd0, 0, 0, 0)); // 18
    vecs.push_back(mk(1, 8'h12, 1, 4'd0, 1, 8'h12, 0, 4'd0, 0, 0, 0)); // 19
    vecs.push_back(mk(1, 8'h12, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 0, 0)); // 20
    // scenario 3: drain to cnt=1, then same-cycle alloc+free on slot 0
    vecs.push_back(mk(0, 8'h00, 1, 4'd0, 1, 8'h12, 1, 4'd1, 0, 0, 0)); // 21
    vecs.push_back(mk(0, 8'h00, 1, 4'd0, 1, 8'h12, 1, 4'd1, 0, 0, 0)); // 22
    vecs.push_back(mk(0, 8'h00, 1, 4'd0, 1, 8'h12, 1, 4'd1, 0, 0, 0)); // 23
    vecs.push_back(mk(1, 8'h12, 1, 4'd0, 1, 8'h12, 1, 4'd0, 0, 0, 0)); // 24
    vecs.push_back(mk(0, 8'h00, 0, 4'd0, 0, 8'h00, 1, 4'd1, 0, 0, 0)); // 25
    vecs.push_back(mk(0, 8'h00, 1, 4'd0, 1, 8'h12, 1, 4'd1, 0, 0, 0)); // 26
    vecs.push_back(mk(0, 8'h00, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 1, 0)); // 27
    // scenario 4: frees of an invalid slot and an out-of-range slot
    vecs.push_back(mk(0, 8'h00, 1, 4'd2, 0, 8'h00, 1, 4'd0, 0, 1, 0)); // 28
    vecs.push_back(mk(0, 8'h00, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 1, 1)); // 29
    vecs.push_back(mk(0, 8'h00, 1, 4'd7, 0, 8'h00, 1, 4'd0, 0, 1, 0)); // 30
    vecs.push_back(mk(0, 8'h00, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 1, 1)); // 31
    vecs.push_back(mk(0, 8'h00, 0, 4'd0, 0, 8'h00, 1, 4'd0, 0, 1, 0)); // 32

    // reset state
    @(negedge clk_i);
    #2;
    chk("rst_ready", 16'(alloc_ready_o), 16'd1);
    chk("rst_full",  16'(full_o),        16'd0);
    chk("rst_empty", 16'(empty_o),       16'd1);
    chk("rst_err",   16'(err_o),         16'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk_i);
      alloc_valid_i = vecs[k].av;
      alloc_id_i    = vecs[k].aid;
      free_valid_i  = vecs[k].fv;
      free_oup_id_i = vecs[k].fid;
      #2;
      $display("vec %0d: av=%0d aid=%02h fv=%0d fid=%0d -> rdy=%0d oup=%0d full=%0d empty=%0d err=%0d inp=%02h",
               k, vecs[k].av, vecs[k].aid, vecs[k].fv, vecs[k].fid,
               alloc_ready_o, alloc_oup_id_o, full_o, empty_o, err_o, free_inp_id_o);
      chk($sformatf("v%0d_ready", k), 16'(alloc_ready_o), 16'(vecs[k].e_rdy));
      chk($sformatf("v%0d_oup",   k), 16'(alloc_oup_id_o), 16'(vecs[k].e_oup));
      chk($sformatf("v%0d_full",  k), 16'(full_o),        16'(vecs[k].e_full));
      chk($sformatf("v%0d_empty", k), 16'(empty_o),       16'(vecs[k].e_empty));
      chk($sformatf("v%0d_err",   k), 16'(err_o),         16'(vecs[k].e_err));
      if (vecs[k].chk_inp)
        chk($sformatf("v%0d_inp", k), 16'(free_inp_id_o), 16'(vecs[k].e_inp));
      if (vecs[k].av && !vecs[k].e_rdy) stall_exp++;
    end

`ifdef AXI_ID_ALLOC_STATS_EN
    chk("stats_peak",  16'(peak_used_o), 16'd4);
    chk("stats_stall", stall_cnt_o,      16'(stall_exp));
`endif

    // scenario 5: asynchronous reset with three slots occupied
    @(negedge clk_i);
    alloc_valid_i = 1'b1; alloc_id_i = 8'h11; free_valid_i = 1'b0;
    #2 chk("s5_oup0", 16'(alloc_oup_id_o), 16'd0);
    @(negedge clk_i);
    alloc_id_i = 8'h22;
    #2 chk("s5_oup1", 16'(alloc_oup_id_o), 16'd1);
    @(negedge clk_i);
    alloc_id_i = 8'h33;
    #2 chk("s5_oup2", 16'(alloc_oup_id_o), 16'd2);
    @(negedge clk_i);
    alloc_valid_i = 1'b0; alloc_id_i = 8'h00;
    #2;
    $display("seq rst: three slots loaded, empty=%0d full=%0d oup=%0d", empty_o, full_o, alloc_oup_id_o);
    chk("s5_pre_empty", 16'(empty_o),        16'd0);
    chk("s5_pre_oup",   16'(alloc_oup_id_o), 16'd3);
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    $display("seq rst: asserted mid-cycle, empty=%0d ready=%0d", empty_o, alloc_ready_o);
    chk("s5_rst_empty", 16'(empty_o),       16'd1);
    chk("s5_rst_ready", 16'(alloc_ready_o), 16'd1);
    chk("s5_rst_full",  16'(full_o),        16'd0);
`ifdef AXI_ID_ALLOC_STATS_EN
    chk("s5_rst_peak",  16'(peak_used_o), 16'd0);
    chk("s5_rst_stall", stall_cnt_o,      16'd0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
    alloc_valid_i = 1'b1; alloc_id_i = 8'h55;
    #2;
    $display("seq rst: alloc 55 after release -> rdy=%0d oup=%0d", alloc_ready_o, alloc_oup_id_o);
    chk("s5_post_ready", 16'(alloc_ready_o),  16'd1);
    chk("s5_post_oup",   16'(alloc_oup_id_o), 16'd0);
    @(negedge clk_i);
    alloc_valid_i = 1'b0; alloc_id_i = 8'h00;
    free_valid_i = 1'b1; free_oup_id_i = 4'd0;
    #2;
    chk("s5_post_empty", 16'(empty_o),       16'd0);
    chk("s5_post_inp",   16'(free_inp_id_o), 16'h55);
    @(negedge clk_i);
    free_valid_i = 1'b0;
    #2 chk("s5_final_empty", 16'(empty_o), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
